// File: rtl/dcache_axi_pkg.sv
// Shared types and AXI encodings for the data-cache AXI bridge.
package dcache_axi_pkg;

   localparam int DEFAULT_LINE_WORDS = 8;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AR,
      ST_R,
      ST_RDONE,
      ST_AW,
      ST_W,
      ST_B,
      ST_WDONE
   } bridge_state_t;

   // Clear the byte-within-line offset of a 32-byte line address.
   function automatic logic [31:0] line_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFE0;
   endfunction

endpackage

// File: rtl/axi_line_buffer.sv
// One cache line of storage: beat-indexed write, parallel load,
// parallel read-out and beat-indexed read.
module axi_line_buffer
   import dcache_axi_pkg::*;
#(
   parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
   parameter int CW         = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic [CW-1:0]                wr_idx,
   input  logic [31:0]                  wr_data,
   input  logic                         load_en,
   input  logic [LINE_WORDS-1:0][31:0]  load_data,
   input  logic [CW-1:0]                rd_idx,
   output logic [31:0]                  rd_data,
   output logic [LINE_WORDS-1:0][31:0]  line
);

   logic [31:0] mem_reg [LINE_WORDS];

   // Line storage: reset clears, a parallel load wins over a beat write.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < LINE_WORDS; i++) mem_reg[i] <= '0;
      end else if (load_en) begin
         for (int i = 0; i < LINE_WORDS; i++) mem_reg[i] <= load_data[i];
      end else if (wr_en) begin
         mem_reg[wr_idx] <= wr_data;
      end
   end

   assign rd_data = mem_reg[rd_idx];

   generate
      for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_line_out
         assign line[gi] = mem_reg[gi];
      end
   endgenerate

endmodule

// File: rtl/dcache_axi_bridge.sv
// Data-cache to AXI4 bridge: line refills as INCR read bursts and,
// when DCACHE_AXI_WB_EN is defined, dirty-line writebacks as write bursts.
module dcache_axi_bridge
   import dcache_axi_pkg::*;
#(
   parameter int         LINE_WORDS = DEFAULT_LINE_WORDS,
   parameter logic [3:0] AXI_ID     = 4'd1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         mem_read_req,
   input  logic [31:0]                  mem_addr,
   output logic [LINE_WORDS-1:0][31:0]  mass_data,
   output logic                         axi_mem_gnt,
   input  logic                         wb_req,
   input  logic [31:0]                  wb_addr,
   input  logic [LINE_WORDS-1:0][31:0]  axi_wr,
   output logic                         wb_done,
   output logic                         bus_err,
   output logic [3:0]                   arid,
   output logic [31:0]                  araddr,
   output logic [7:0]                   arlen,
   output logic [2:0]                   arsize,
   output logic [1:0]                   arburst,
   output logic                         arvalid,
   input  logic                         arready,
   input  logic [3:0]                   rid,
   input  logic [31:0]                  rdata,
   input  logic [1:0]                   rresp,
   input  logic                         rlast,
   input  logic                         rvalid,
   output logic                         rready,
   output logic [3:0]                   awid,
   output logic [31:0]                  awaddr,
   output logic [7:0]                   awlen,
   output logic [2:0]                   awsize,
   output logic [1:0]                   awburst,
   output logic                         awvalid,
   input  logic                         awready,
   output logic [31:0]                  wdata,
   output logic [3:0]                   wstrb,
   output logic                         wlast,
   output logic                         wvalid,
   input  logic                         wready,
   input  logic [1:0]                   bresp,
   input  logic                         bvalid,
   output logic                         bready
);

   localparam int CW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

   bridge_state_t state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [31:0]   addr_reg, addr_next;
   logic          bus_err_reg, bus_err_next;
   logic          last_beat;
   logic          r_beat;
   logic [31:0]   refill_rd_unused;
   logic          unused_sink;

   assign last_beat = (cnt_reg == CW'(LINE_WORDS - 1));
   assign r_beat    = (state_reg == ST_R) && rvalid;

   axi_line_buffer #(.LINE_WORDS(LINE_WORDS), .CW(CW)) u_refill_buf (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (r_beat),
      .wr_idx    (cnt_reg),
      .wr_data   (rdata),
      .load_en   (1'b0),
      .load_data ('0),
      .rd_idx    (cnt_reg),
      .rd_data   (refill_rd_unused),
      .line      (mass_data)
   );

`ifdef DCACHE_AXI_WB_EN
   logic                         wb_load;
   logic [31:0]                  wbuf_rd;
   logic [LINE_WORDS-1:0][31:0]  wbuf_line_unused;

   axi_line_buffer #(.LINE_WORDS(LINE_WORDS), .CW(CW)) u_wb_buf (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (1'b0),
      .wr_idx    (cnt_reg),
      .wr_data   (32'h0),
      .load_en   (wb_load),
      .load_data (axi_wr),
      .rd_idx    (cnt_reg),
      .rd_data   (wbuf_rd),
      .line      (wbuf_line_unused)
   );

   assign wdata       = wbuf_rd;
   assign wlast       = (state_reg == ST_W) && last_beat;
   assign unused_sink = ^{rid, refill_rd_unused, wbuf_line_unused};
`else
   assign wdata       = 32'h0;
   assign wlast       = 1'b0;
   assign unused_sink = ^{rid, refill_rd_unused, wb_req, wb_addr, axi_wr,
                          awready, wready, bresp, bvalid};
`endif

   // Address-channel fields are constant apart from the latched line address.
   assign arid    = AXI_ID;
   assign araddr  = addr_reg;
   assign arlen   = 8'(LINE_WORDS - 1);
   assign arsize  = AXI_SIZE_WORD;
   assign arburst = AXI_BURST_INCR;
   assign awid    = AXI_ID;
   assign awaddr  = addr_reg;
   assign awlen   = 8'(LINE_WORDS - 1);
   assign awsize  = AXI_SIZE_WORD;
   assign awburst = AXI_BURST_INCR;
   assign wstrb   = 4'hF;
   assign bus_err = bus_err_reg;

   // State, beat counter, line address and sticky error registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         addr_reg    <= '0;
         bus_err_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         addr_reg    <= addr_next;
         bus_err_reg <= bus_err_next;
      end
   end

   // Next-state and output decode; writeback wins over refill in IDLE.
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      addr_next    = addr_reg;
      bus_err_next = bus_err_reg;
      arvalid      = 1'b0;
      rready       = 1'b0;
      axi_mem_gnt  = 1'b0;
      awvalid      = 1'b0;
      wvalid       = 1'b0;
      bready       = 1'b0;
      wb_done      = 1'b0;
`ifdef DCACHE_AXI_WB_EN
      wb_load      = 1'b0;
`endif
      case (state_reg)
         ST_IDLE: begin
            cnt_next = '0;
`ifdef DCACHE_AXI_WB_EN
            if (wb_req) begin
               addr_next  = line_align(wb_addr);
               wb_load    = 1'b1;
               state_next = ST_AW;
            end else
`endif
            if (mem_read_req) begin
               addr_next  = line_align(mem_addr);
               state_next = ST_AR;
            end
         end
         ST_AR: begin
            arvalid = 1'b1;
            if (arready) begin
               cnt_next   = '0;
               state_next = ST_R;
            end
         end
         ST_R: begin
            rready = 1'b1;
            if (rvalid) begin
               if ((rresp != AXI_RESP_OKAY) || (rlast != last_beat)) bus_err_next = 1'b1;
               if (last_beat) begin
                  cnt_next   = '0;
                  state_next = ST_RDONE;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end
         ST_RDONE: begin
            axi_mem_gnt = 1'b1;
            state_next  = ST_IDLE;
         end
`ifdef DCACHE_AXI_WB_EN
         ST_AW: begin
            awvalid = 1'b1;
            if (awready) begin
               cnt_next   = '0;
               state_next = ST_W;
            end
         end
         ST_W: begin
            wvalid = 1'b1;
            if (wready) begin
               if (last_beat) begin
                  cnt_next   = '0;
                  state_next = ST_B;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end
         ST_B: begin
            bready = 1'b1;
            if (bvalid) begin
               if (bresp != AXI_RESP_OKAY) bus_err_next = 1'b1;
               state_next = ST_WDONE;
            end
         end
         ST_WDONE: begin
            wb_done    = 1'b1;
            state_next = ST_IDLE;
         end
`endif
         default: state_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Directed bench for dcache_axi_bridge: refill timing, rvalid gaps,
// read errors, reset mid-burst and the writeback path (DCACHE_AXI_WB_EN).
module tb_dcache_axi_bridge;
   import dcache_axi_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              mem_read_req;
   logic [31:0]       mem_addr;
   logic [7:0][31:0]  mass_data;
   logic              axi_mem_gnt;
   logic              wb_req;
   logic [31:0]       wb_addr;
   logic [7:0][31:0]  axi_wr;
   logic              wb_done;
   logic              bus_err;
   logic [3:0]        arid;
   logic [31:0]       araddr;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic              arvalid;
   logic              arready;
   logic [3:0]        rid;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic              rvalid;
   logic              rready;
   logic [3:0]        awid;
   logic [31:0]       awaddr;
   logic [7:0]        awlen;
   logic [2:0]        awsize;
   logic [1:0]        awburst;
   logic              awvalid;
   logic              awready;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              wlast;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;

   int vectors     = 0;
   int miscompares = 0;
   bit aw_seen     = 0;

   always #5 clk = ~clk;

   dcache_axi_bridge #(.LINE_WORDS(8), .AXI_ID(4'd1)) dut (
      .clk(clk), .rst(rst),
      .mem_read_req(mem_read_req), .mem_addr(mem_addr),
      .mass_data(mass_data), .axi_mem_gnt(axi_mem_gnt),
      .wb_req(wb_req), .wb_addr(wb_addr), .axi_wr(axi_wr),
      .wb_done(wb_done), .bus_err(bus_err),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .awburst(awburst), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
      .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one refill as a zero-wait slave (optional gap, error beat, reset abort).
   task automatic refill(input string name, input logic [31:0] addr, input logic [31:0] exp_araddr,
                         input logic [31:0] base, input int gap_at, input int gap_len,
                         input int err_beat, input int abort_beat,
                         input int exp_ar_cyc, input int exp_gnt_cyc);
      int   cyc = 0;
      int   beat = 0;
      int   gap = 0;
      int   gnt_cyc = -1;
      int   ar_cyc = -1;
      logic aborted = 1'b0;
      mem_read_req = 1'b1;
      mem_addr     = addr;
      while (cyc < 40 && gnt_cyc < 0 && !aborted) begin
         @(posedge clk); #1;
         cyc++;
         arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = AXI_RESP_OKAY; rdata = 32'h0;
         if (awvalid || wvalid || bready || wb_done) aw_seen = 1;
         if (arvalid) begin
            if (ar_cyc < 0) begin
               ar_cyc = cyc;
               check({name, ".araddr"}, araddr, exp_araddr);
               check({name, ".arlen"}, 32'(arlen), 32'd7);
               check({name, ".arsize"}, 32'(arsize), 32'd2);
               check({name, ".arburst"}, 32'(arburst), 32'd1);
               check({name, ".arid"}, 32'(arid), 32'd1);
            end
            arready = 1'b1;
         end
         if (axi_mem_gnt) begin
            gnt_cyc      = cyc;
            mem_read_req = 1'b0;
         end else if (rready && beat < 8) begin
            if (beat == gap_at && gap < gap_len) begin
               gap++;
            end else begin
               rvalid = 1'b1;
               rdata  = base + 32'(beat);
               rlast  = (beat == 7);
               if (beat == err_beat) rresp = 2'b10;
               if (beat == abort_beat) begin
                  rst     = 1'b0;
                  aborted = 1'b1;
               end
               beat++;
            end
         end
      end
      if (!aborted) begin
         check({name, ".ar_cycle"}, 32'(ar_cyc), 32'(exp_ar_cyc));
         check({name, ".gnt_cycle"}, 32'(gnt_cyc), 32'(exp_gnt_cyc));
         for (int i = 0; i < 8; i++)
            check($sformatf("%s.word%0d", name, i), mass_data[i], base + 32'(i));
         @(posedge clk); #1;
         check({name, ".gnt_one_cycle"}, 32'(axi_mem_gnt), 32'd0);
         check({name, ".no_dup_ar1"}, 32'(arvalid), 32'd0);
         @(posedge clk); #1;
         check({name, ".no_dup_ar2"}, 32'(arvalid), 32'd0);
         $display("refill %s addr=%h gnt_cycle=%0d bus_err=%0b", name, addr, gnt_cyc, bus_err);
      end
   endtask

`ifdef DCACHE_AXI_WB_EN
   // Writeback of 0xB0..0xB7 to 0x8000_0040 with a refill request pending.
   task automatic writeback();
      int   cyc = 0;
      int   wbeat = 0;
      int   done_cyc = -1;
      int   wlast_cnt = 0;
      int   early_w = 0;
      int   ar_early = 0;
      logic aw_done = 1'b0;
      wb_req       = 1'b1;
      wb_addr      = 32'h8000_0040;
      for (int i = 0; i < 8; i++) axi_wr[i] = 32'hB0 + 32'(i);
      mem_read_req = 1'b1;
      mem_addr     = 32'h0000_3000;
      while (cyc < 40 && done_cyc < 0) begin
         @(posedge clk); #1;
         cyc++;
         awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = AXI_RESP_OKAY;
         if (arvalid) ar_early++;
         if (wvalid) begin
            if (!aw_done) early_w++;
            check($sformatf("wb.wdata%0d", wbeat), wdata, 32'hB0 + 32'(wbeat));
            check($sformatf("wb.wlast%0d", wbeat), 32'(wlast), 32'(wbeat == 7));
            if (wlast) wlast_cnt++;
            wready = 1'b1;
            wbeat++;
         end
         if (awvalid) begin
            if (!aw_done) begin
               check("wb.awaddr", awaddr, 32'h8000_0040);
               check("wb.awlen", 32'(awlen), 32'd7);
               check("wb.awburst", 32'(awburst), 32'd1);
            end
            aw_done = 1'b1;
            awready = 1'b1;
         end
         if (bready) bvalid = 1'b1;
         if (wb_done) begin
            done_cyc = cyc;
            wb_req   = 1'b0;
         end
      end
      check("wb.done_cycle", 32'(done_cyc), 32'd11);
      check("wb.beats", 32'(wbeat), 32'd8);
      check("wb.wlast_count", 32'(wlast_cnt), 32'd1);
      check("wb.w_before_aw", 32'(early_w), 32'd0);
      check("wb.ar_before_done", 32'(ar_early), 32'd0);
      $display("writeback addr=%h done_cycle=%0d beats=%0d", wb_addr, done_cyc, wbeat);
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; mem_read_req = 1'b0; mem_addr = 32'h0;
      wb_req = 1'b0; wb_addr = 32'h0; axi_wr = '0;
      arready = 1'b0; rid = 4'd1; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
      awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst.arvalid", 32'(arvalid), 32'd0);
      check("rst.rready", 32'(rready), 32'd0);
      check("rst.gnt", 32'(axi_mem_gnt), 32'd0);
      check("rst.bus_err", 32'(bus_err), 32'd0);
      check("rst.awvalid", 32'(awvalid), 32'd0);
      check("rst.wvalid", 32'(wvalid), 32'd0);
      check("rst.bready", 32'(bready), 32'd0);
      check("rst.wb_done", 32'(wb_done), 32'd0);
      check("rst.mass_data3", mass_data[3], 32'h0);
      $display("reset applied");
      rst = 1'b1;

      // Zero-wait refill
      refill("basic", 32'h1234_5678, 32'h1234_5660, 32'hA0, 99, 0, 99, 99, 1, 10);
      check("basic.bus_err", 32'(bus_err), 32'd0);

      // rvalid gap of three cycles after beat 2
      refill("gap", 32'h0000_1F00, 32'h0000_1F00, 32'hC0, 3, 3, 99, 99, 1, 13);
      check("gap.bus_err", 32'(bus_err), 32'd0);

`ifdef DCACHE_AXI_WB_EN
      // Writeback and refill requested together: writeback first
      aw_seen = 0;
      writeback();
      refill("after_wb", 32'h0000_3000, 32'h0000_3000, 32'hF0, 99, 0, 99, 99, 2, 11);
      check("after_wb.no_aw", 32'(aw_seen), 32'd0);
`else
      // Writeback request ignored when the write path is compiled out
      aw_seen = 0;
      wb_req  = 1'b1;
      wb_addr = 32'h8000_0040;
      for (int i = 0; i < 8; i++) axi_wr[i] = 32'hB0 + 32'(i);
      refill("wb_off", 32'h0000_3000, 32'h0000_3000, 32'hF0, 99, 0, 99, 99, 1, 10);
      check("wb_off.no_write_activity", 32'(aw_seen), 32'd0);
      wb_req = 1'b0;
`endif

      // Error response on beat 5, then a clean refill keeps the sticky flag
      refill("rerr", 32'h0000_4000, 32'h0000_4000, 32'hD0, 99, 0, 5, 99, 1, 10);
      check("rerr.bus_err", 32'(bus_err), 32'd1);
      refill("clean", 32'h0000_5020, 32'h0000_5020, 32'hE0, 99, 0, 99, 99, 1, 10);
      check("clean.bus_err_sticky", 32'(bus_err), 32'd1);

      // Reset asserted during beat 4
      refill("abort", 32'h0000_6000, 32'h0000_6000, 32'h50, 99, 0, 99, 4, 1, 10);
      @(posedge clk); #1;
      check("abort.rready", 32'(rready), 32'd0);
      check("abort.arvalid", 32'(arvalid), 32'd0);
      check("abort.gnt", 32'(axi_mem_gnt), 32'd0);
      check("abort.bus_err", 32'(bus_err), 32'd0);
      for (int i = 0; i < 8; i++)
         check($sformatf("abort.word%0d", i), mass_data[i], 32'h0);
      rst = 1'b1; mem_read_req = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = 32'h0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check($sformatf("abort.idle_gnt%0d", i), 32'(axi_mem_gnt), 32'd0);
         check($sformatf("abort.idle_ar%0d", i), 32'(arvalid), 32'd0);
      end
      $display("reset mid-burst at beat 4 handled");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
